// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//
// Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// sck is derived from clk by an integer half-period divider. Each half-period
// lasts CLK_DIV clk cycles, so a byte takes 16*CLK_DIV cycles.
//
// Parameters
//   CLK_DIV : clk cycles per sck half-period (2..255)
//   DIV_W   : width of the half-period counter (CLK_DIV-1 must fit)
//
// Ports
//   clk   in   system clock
//   rst   in   synchronous, active-high reset
//   start in   transfer request, sampled only while idle
//   din   in   byte to send, captured on the accepted start edge
//   busy  out  high while a transfer is in progress
//   done  out  one-cycle pulse when dout is updated
//   dout  out  last received byte, held until the next done
//   sck   out  SPI clock, idles low
//   mosi  out  SPI data out, holds the last bit sent between transfers
//   miso  in   SPI data in, sampled on the rising sck edge
//   ss    out  active-low slave select (only with SPI_MASTER_AUTO_SS_EN)
//
// Build option
//   SPI_MASTER_AUTO_SS_EN : when defined, adds the ss port and frames each
//                           byte with it automatically.
// -----------------------------------------------------------------------------
module spi_master #(
    parameter int CLK_DIV = 4,
    parameter int DIV_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic [7:0] dout,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
`ifdef SPI_MASTER_AUTO_SS_EN
    ,
    output logic       ss
`endif
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div_ct;
    logic [2:0]       r_bit_ct;
    // Only the bits still to be sent live here; bit 7 goes straight to mosi
    // at the start edge, so the register is 7 bits wide.
    logic [6:0]       r_tx;
    logic [7:0]       r_rx;
    logic [7:0]       r_dout;
    logic             r_busy;
    logic             r_done;
    logic             r_sck;
    logic             r_mosi;
`ifdef SPI_MASTER_AUTO_SS_EN
    logic             r_ss;
`endif

    wire w_half_end = (r_div_ct == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_div_ct <= '0;
            r_bit_ct <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
            r_dout   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sck    <= 1'b0;
            r_mosi   <= 1'b0;
`ifdef SPI_MASTER_AUTO_SS_EN
            r_ss     <= 1'b1;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_tx     <= din[6:0];
                        r_mosi   <= din[7];
                        r_bit_ct <= '0;
                        r_div_ct <= '0;
                        r_busy   <= 1'b1;
`ifdef SPI_MASTER_AUTO_SS_EN
                        r_ss     <= 1'b0;
`endif
                        r_state  <= LOW;
                    end
                end

                LOW: begin
                    if (w_half_end) begin
                        // Rising sck: the slave has had a full low
                        // half-period to present its bit, so sample now.
                        r_sck    <= 1'b1;
                        r_rx     <= {r_rx[6:0], miso};
                        r_div_ct <= '0;
                        r_state  <= HIGH;
                    end else begin
                        r_div_ct <= r_div_ct + 1'b1;
                    end
                end

                HIGH: begin
                    if (w_half_end) begin
                        r_sck    <= 1'b0;
                        r_div_ct <= '0;
                        if (r_bit_ct == 3'd7) begin
                            // All eight bits are already in r_rx.
                            r_dout  <= r_rx;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
`ifdef SPI_MASTER_AUTO_SS_EN
                            r_ss    <= 1'b1;
`endif
                            r_state <= IDLE;
                        end else begin
                            // Falling sck: present the next bit for the
                            // slave to sample on the following rising edge.
                            r_tx     <= {r_tx[5:0], 1'b0};
                            r_mosi   <= r_tx[6];
                            r_bit_ct <= r_bit_ct + 3'd1;
                            r_state  <= LOW;
                        end
                    end else begin
                        r_div_ct <= r_div_ct + 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dout = r_dout;
    assign sck  = r_sck;
    assign mosi = r_mosi;
`ifdef SPI_MASTER_AUTO_SS_EN
    assign ss   = r_ss;
`endif

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//
// Directed bench for spi_master with CLK_DIV=4. miso is selected from a
// loopback of mosi, a constant 1, a constant 0, or a small mode-0 slave model
// (samples on rising sck, shifts on falling sck, observed on clk).
// -----------------------------------------------------------------------------
module tb_spi_master;

    localparam int CLK_DIV = 4;
    localparam int XFER    = 16 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic       busy;
    logic       done;
    logic [7:0] dout;
    logic       sck;
    logic       mosi;
    logic       miso;
`ifdef SPI_MASTER_AUTO_SS_EN
    logic       ss;
`endif

    spi_master #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .sck   (sck),
        .mosi  (mosi),
        .miso  (miso)
`ifdef SPI_MASTER_AUTO_SS_EN
        ,
        .ss    (ss)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // miso source: 0 loopback, 1 const 1, 2 const 0, 3 slave model
    logic [1:0] mode = 2'd0;
    logic [7:0] s_tx = 8'h00;
    logic [7:0] s_rx = 8'h00;
    logic       s_load = 1'b1;
    int         s_cnt = 0;
    int         s_done_ct = 0;

    assign miso = (mode == 2'd0) ? mosi :
                  (mode == 2'd1) ? 1'b1 :
                  (mode == 2'd2) ? 1'b0 : s_tx[7];

    // Monitor and slave model, sampled on the falling clk edge.
    logic sck_d = 1'b0;
    int   rise_ct = 0;
    int   busy_ct = 0;
    int   mosi_hi_ct = 0;
    int   done_ct = 0;

    always @(negedge clk) begin
        sck_d <= sck;
        if (sck === 1'b1 && sck_d === 1'b0) rise_ct <= rise_ct + 1;
        if (busy === 1'b1) busy_ct <= busy_ct + 1;
        if (mosi === 1'b1) mosi_hi_ct <= mosi_hi_ct + 1;
        if (done === 1'b1) done_ct <= done_ct + 1;
        if (s_load) begin
            s_tx  <= 8'h3C;
            s_rx  <= 8'h00;
            s_cnt <= 0;
        end else if (sck === 1'b1 && sck_d === 1'b0) begin
            s_rx  <= {s_rx[6:0], mosi};
            s_cnt <= s_cnt + 1;
            if (s_cnt == 7) s_done_ct <= s_done_ct + 1;
        end else if (sck === 1'b0 && sck_d === 1'b1) begin
            s_tx <= {s_tx[6:0], 1'b0};
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulses start for one cycle; e0 is the index of the accepting edge.
    task automatic launch(input logic [7:0] b, output int e0);
        @(negedge clk);
        din   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0    = cyc;
    endtask

    // Returns the index of the edge that raised done, or -1 on timeout.
    task automatic wait_done(input string tag, output int c);
        c = -1;
        for (int k = 0; k < 400; k++) begin
            if (done === 1'b1) begin
                c = cyc;
                break;
            end
            @(negedge clk);
        end
        if (c < 0) check({tag, " done timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, c, c1, c2;
        int r0, b0, d0, m0, sd0;

        rst   = 1'b1;
        start = 1'b0;
        din   = 8'h00;
        mode  = 2'd0;
        s_load = 1'b1;
        idle(3);
        check("reset sck",  32'(sck),  32'd0);
        check("reset mosi", 32'(mosi), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset dout", 32'(dout), 32'h00);
`ifdef SPI_MASTER_AUTO_SS_EN
        check("reset ss",   32'(ss),   32'd1);
`endif
        $display("reset: sck=%0b busy=%0b dout=%02h", sck, busy, dout);
        rst    = 1'b0;
        s_load = 1'b0;
        idle(2);

        // Loopback A5: latency, pulse width, edge count, busy length.
        r0 = rise_ct; b0 = busy_ct; d0 = done_ct;
        launch(8'hA5, e0);
        check("a5 mosi msb", 32'(mosi), 32'd1);
        check("a5 busy",     32'(busy), 32'd1);
`ifdef SPI_MASTER_AUTO_SS_EN
        check("a5 ss low",   32'(ss),   32'd0);
`endif
        wait_done("a5", c);
        check("a5 latency", 32'(c - e0), 32'(XFER));
        check("a5 dout",    32'(dout),   32'hA5);
        @(negedge clk);
        check("a5 done width", 32'(done), 32'd0);
        idle(4);
        check("a5 sck rises",  32'(rise_ct - r0), 32'd8);
        check("a5 busy cycles", 32'(busy_ct - b0), 32'(XFER));
        check("a5 done count", 32'(done_ct - d0), 32'd1);
        check("a5 sck idle",   32'(sck),  32'd0);
        check("a5 mosi hold",  32'(mosi), 32'd1);
        $display("xfer loopback din=a5 dout=%02h latency=%0d", dout, c - e0);

        // miso tied 1, din 00: mosi must stay low throughout.
        mode = 2'd1;
        idle(2);
        launch(8'h00, e0);
        m0 = mosi_hi_ct;
        wait_done("ff", c);
        idle(4);
        check("miso1 dout",     32'(dout), 32'hFF);
        check("miso1 mosi low", 32'(mosi_hi_ct - m0), 32'd0);
        $display("xfer miso=1 din=00 dout=%02h", dout);

        // miso tied 0.
        mode = 2'd2;
        idle(2);
        launch(8'hFF, e0);
        wait_done("zero", c);
        check("miso0 dout",    32'(dout),   32'h00);
        check("miso0 latency", 32'(c - e0), 32'(XFER));
        idle(4);
        $display("xfer miso=0 din=ff dout=%02h", dout);

        // Second start at E0+10 during a transfer is ignored.
        mode = 2'd0;
        idle(2);
        d0 = done_ct;
        launch(8'h3C, e0);
        repeat (9) @(negedge clk);
        din   = 8'hC3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", c);
        check("ignore dout", 32'(dout), 32'h3C);
        idle(100);
        check("ignore done count", 32'(done_ct - d0), 32'd1);
        check("ignore busy",       32'(busy),          32'd0);
        $display("xfer ignored-start din=3c dout=%02h", dout);

        // Reset at E0+30 aborts the transfer with no done.
        idle(2);
        d0 = done_ct;
        launch(8'h5A, e0);
        repeat (28) @(negedge clk);
        check("abort sck high before rst", 32'(sck), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort sck",  32'(sck),  32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort dout", 32'(dout), 32'h00);
        check("abort done", 32'(done), 32'd0);
`ifdef SPI_MASTER_AUTO_SS_EN
        check("abort ss",   32'(ss),   32'd1);
`endif
        rst = 1'b0;
        idle(100);
        check("abort no done", 32'(done_ct - d0), 32'd0);
        $display("xfer abort din=5a dout=%02h busy=%0b", dout, busy);

        // start held high: back-to-back bytes with a one-cycle gap.
        @(negedge clk);
        din   = 8'h01;
        start = 1'b1;
        @(negedge clk);
        e0 = cyc;
        wait_done("b2b first", c1);
        check("b2b first latency", 32'(c1 - e0), 32'(XFER));
        check("b2b first dout",    32'(dout),    32'h01);
        check("b2b gap busy",      32'(busy),    32'd0);
`ifdef SPI_MASTER_AUTO_SS_EN
        check("b2b gap ss",        32'(ss),      32'd1);
`endif
        din = 8'h80;
        @(negedge clk);
        check("b2b second busy", 32'(busy), 32'd1);
`ifdef SPI_MASTER_AUTO_SS_EN
        check("b2b second ss",   32'(ss),   32'd0);
`endif
        start = 1'b0;
        wait_done("b2b second", c2);
        check("b2b spacing",     32'(c2 - c1), 32'(XFER + 1));
        check("b2b second dout", 32'(dout),    32'h80);
        idle(4);
        $display("xfer back-to-back 01/80 dout=%02h spacing=%0d", dout, c2 - c1);

        // Against the slave model: master sends C3, slave sends 3C.
        mode   = 2'd3;
        s_load = 1'b1;
        idle(2);
        s_load = 1'b0;
        idle(1);
        sd0 = s_done_ct;
        launch(8'hC3, e0);
        wait_done("slave", c);
        idle(4);
        check("slave master dout", 32'(dout),            32'h3C);
        check("slave rx",          32'(s_rx),            32'hC3);
        check("slave done",        32'(s_done_ct - sd0), 32'd1);
        $display("xfer slave master_dout=%02h slave_dout=%02h", dout, s_rx);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
SPI mode-0 (CPOL=0, CPHA=0) single-byte master, MSB first. It is the initiator counterpart to the team's mode-0 SPI slave, which samples on rising sck and shifts on falling sck. It drives the ledsuit panel-side SPI links and the on-board loopback tests from the FPGA system clock. sck is generated by a programmable integer divider.

Parameters:
CLK_DIV, 4, number of clk cycles per sck half-period; legal range 2..255. Use at least 4 when talking to the team's 2-flop-synchronised slave on the same clk.
DIV_W, 8, width of the half-period counter; must satisfy CLK_DIV-1 < 2**DIV_W.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  request a transfer; sampled only in IDLE
din  input  8  byte to transmit; captured on the accepted start edge
busy  output  1  high while a transfer is in progress
done  output  1  single-cycle pulse when dout is valid
dout  output  8  last received byte; held until the next done
sck  output  1  SPI clock, idles low
mosi  output  1  SPI data out
miso  input  1  SPI data in; registered at the sampling edge, no extra synchroniser
ss  output  1  active-low slave select; present only with SPI_MASTER_AUTO_SS_EN

Behaviour:
- Clock and reset: clk is the system clock. rst is synchronous and active-high.
- Reset values (all registered outputs): sck=0, mosi=0, busy=0, done=0, dout=8'h00, ss=1. FSM returns to IDLE; counters and shift register are cleared.
- Reset mid-transfer aborts the transfer immediately. No done pulse is produced and dout is unchanged from reset (8'h00).
- FSM states: IDLE, LOW (sck low half-period), HIGH (sck high half-period).
- IDLE, start=1 at edge E0:
  - shift register <= din; mosi <= din[7]; bit_ct <= 0; div_ct <= 0.
  - busy <= 1; go to LOW.
- LOW:
  - div_ct increments each clk.
  - When div_ct == CLK_DIV-1: sck <= 1; rx[0] captures miso, shifting rx left; div_ct <= 0; go to HIGH.
- HIGH:
  - div_ct increments each clk.
  - When div_ct == CLK_DIV-1: sck <= 0; div_ct <= 0.
  - If bit_ct == 7: dout <= {rx[6:0], sampled bit}, i.e. the full 8 received bits; done <= 1 for one cycle; busy <= 0; go to IDLE.
  - Else: shift the tx register left; mosi <= next bit; bit_ct <= bit_ct+1; go to LOW.
- Latency: done is high in the cycle after edge E0 + 16*CLK_DIV. busy is high for exactly 16*CLK_DIV cycles.
- sck timing: sck gives exactly 8 rising edges per transfer and ends low. mosi changes only on sck falling edges, or at E0.
- mosi after the transfer holds the last bit (din[0]) until the next start.
- start while busy: ignored; din is not sampled.
- start in the done cycle: the FSM is already in IDLE, so the new transfer is accepted. This gives back-to-back bytes with a 1-cycle gap.
- start held high continuously: produces back-to-back transfers.
- dout and done are registered; no combinational path from miso to any output.

Optional Feature:
SPI_MASTER_AUTO_SS_EN
- Defined: ss port exists. ss <= 0 on the accepted start edge and ss <= 1 on the edge that raises done. A back-to-back start in the done cycle still deasserts ss for one cycle.
- Not defined: ss port is absent; slave select is driven externally by the user logic.

Test Plan:
- CLK_DIV=4, mosi looped to miso, start with din=8'hA5 -> dout=8'hA5; done 1-cycle pulse at E0+64; exactly 8 sck rising edges; busy high for 64 cycles.
- miso tied 1, din=8'h00 -> dout=8'hFF. miso tied 0 -> dout=8'h00. mosi=0 throughout the din=8'h00 transfer.
- Pulse start again at E0+10 during a transfer -> ignored; one done only; dout unchanged by the second din.
- Assert rst at E0+30 of a din=8'h5A transfer -> next cycle sck=0, busy=0, ss=1, dout=8'h00; no done ever pulses.
- start held high, din=8'h01 then 8'h80 -> two done pulses 65 cycles apart; ss goes high for one cycle between them (macro on).
- Master with the team's SPI slave on the same clk, CLK_DIV=4, macro on: master din=8'hC3, slave din=8'h3C -> master dout=8'h3C, slave dout=8'hC3 with a slave done pulse.
